spi_regslave: RTL and testbench

Parametrised AVR-facing SPI slave register file for the FPGA. It carries N_REGS write registers of DATA_W bits each, selected by an 8-bit register number, with per-register commit strobes. It adds frame-length checking and read-back, which fixed-function slave decoders do not provide. It sits between the AVR SPI pins and the FPGA consumers: keyboard, mouse, config, wait and similar.

---
 rtl/spi_regslave_pkg.sv | 34 +++
 rtl/spi_sync_edge.sv | 43 ++++
 rtl/spi_regslave.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_regslave.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regslave_pkg.sv
// spi_regslave_pkg
// Shared definitions for the AVR-facing SPI register slave: legal parameter
// ranges, the default register base, the phase-state encoding and a
// parameter-legality helper used by the top level.
// No ports (package).
// Related build macro: SPI_READBACK_EN (consumed by spi_regslave).

package spi_regslave_pkg;

    localparam int DATA_W_MIN      = 8;
    localparam int DATA_W_MAX      = 64;
    localparam int N_REGS_MIN      = 1;
    localparam int N_REGS_MAX      = 16;
    localparam int SYNC_STAGES_MIN = 2;

    localparam logic [7:0] BASE_ADDR_DEFAULT = 8'h40;

    // Phase of the SPI transaction, follows the synchronised chip-select level.
    typedef enum logic {
        PH_ADDR = 1'b0,
        PH_DATA = 1'b1
    } phase_e;

    // True when the parameter set describes a register map that fits the
    // 8-bit register-number space and a safe synchroniser depth.
    function automatic bit params_legal(input int data_w, input int n_regs,
                                        input logic [7:0] base, input int stages);
        return (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) &&
               (n_regs >= N_REGS_MIN) && (n_regs <= N_REGS_MAX) &&
               ((int'(base) + n_regs - 1) <= 255) &&
               (stages >= SYNC_STAGES_MIN);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// Multi-flop synchroniser for one asynchronous SPI pin, followed by one extra
// flop so that rising and falling edges of the synchronised level can be
// reported as single-cycle pulses.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (whole chain resets to RST_VAL)
//   d     in  asynchronous pin
//   level out synchronised level
//   rise  out one-cycle pulse on a synchronised 0->1 transition
//   fall  out one-cycle pulse on a synchronised 1->0 transition

module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchroniser chain plus the edge-detect history stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RST_VAL}};
            prev_r <= RST_VAL;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = sync_r[STAGES-1] & ~prev_r;
    assign fall  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_regslave.sv
// spi_regslave
// SPI (mode 0) slave register file for the AVR. An 8-bit register number is
// shifted in LSB first while chip select is high; while chip select is low a
// DATA_W-bit data frame is exchanged. On the closing chip-select edge a frame
// of exactly DATA_W bits to a valid register is committed and strobed; any
// other non-zero length to a valid register sets a sticky frame error.
// Build macro SPI_READBACK_EN: when defined the data phase returns the
// committed register value instead of rd_in.
// Ports:
//   fclk      in  system clock
//   rst_n     in  asynchronous active-low reset
//   spics_n   in  SPI chip select (async)
//   spick     in  SPI clock (async)
//   spido     in  SPI MOSI (async)
//   spidi     out SPI MISO
//   status_in in  status byte returned during the address phase
//   rd_in     in  per-register read data, lane i at [i*DATA_W +: DATA_W]
//   wr_data   out committed register values, same lane layout
//   wr_stb    out one-cycle commit pulse per register
//   frame_err out sticky wrong-length flag
//   err_clr   in  synchronous clear of frame_err

module spi_regslave
    import spi_regslave_pkg::*;
#(
    parameter int         DATA_W      = 8,
    parameter int         N_REGS      = 4,
    parameter logic [7:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     fclk,
    input  logic                     rst_n,
    input  logic                     spics_n,
    input  logic                     spick,
    input  logic                     spido,
    output logic                     spidi,
    input  logic [7:0]               status_in,
    input  logic [N_REGS*DATA_W-1:0] rd_in,
    output logic [N_REGS*DATA_W-1:0] wr_data,
    output logic [N_REGS-1:0]        wr_stb,
    output logic                     frame_err,
    input  logic                     err_clr
);

    // Counter is sized for the widest legal register so it can hold DATA_W+1.
    localparam int              CNT_W    = $clog2(DATA_W_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);
    // A misconfigured instance decodes no register and therefore never writes.
    localparam bit PARAMS_OK = params_legal(DATA_W, N_REGS, BASE_ADDR, SYNC_STAGES);

    logic cs_lvl_s, cs_rise_s, cs_fall_s;
    logic sck_lvl_s, sck_rise_s, sck_fall_s;
    logic [SYNC_STAGES-1:0] sdo_sync_r;
    logic sdo_s;

    phase_e state_r, state_nxt_s;

    logic [7:0]               regnum_r;
    logic [CNT_W-1:0]         bitcnt_r;
    logic [DATA_W-1:0]        shift_in_r;
    logic [DATA_W-1:0]        shift_out_r;
    logic [N_REGS*DATA_W-1:0] wr_data_r;
    logic [N_REGS-1:0]        commit_r;
    logic [N_REGS-1:0]        wr_stb_r;
    logic                     frame_err_r;

    logic [7:0]        off_s;
    logic              valid_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              set_err_s;
    logic              unused_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk   (fclk),
        .rst_n (rst_n),
        .d     (spics_n),
        .level (cs_lvl_s),
        .rise  (cs_rise_s),
        .fall  (cs_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk   (fclk),
        .rst_n (rst_n),
        .d     (spick),
        .level (sck_lvl_s),
        .rise  (sck_rise_s),
        .fall  (sck_fall_s)
    );

    // MOSI needs only a level; same depth as SCK so it is aligned with sck_rise_s.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            sdo_sync_r <= '0;
        end else begin
            sdo_sync_r <= {sdo_sync_r[SYNC_STAGES-2:0], spido};
        end
    end
    assign sdo_s = sdo_sync_r[SYNC_STAGES-1];

    // Phase state register.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= PH_ADDR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Phase next-state: CS high is the address phase, CS low the data phase.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            PH_ADDR: begin
                if (!cs_lvl_s) begin
                    state_nxt_s = PH_DATA;
                end else begin
                    state_nxt_s = PH_ADDR;
                end
            end
            PH_DATA: begin
                if (cs_lvl_s) begin
                    state_nxt_s = PH_ADDR;
                end else begin
                    state_nxt_s = PH_DATA;
                end
            end
            default: state_nxt_s = PH_ADDR;
        endcase
    end

    // Register decode; the offset is computed in 8 bits before comparison.
    always_comb begin
        off_s   = regnum_r - BASE_ADDR;
        valid_s = PARAMS_OK && (regnum_r >= BASE_ADDR) && (off_s < 8'(N_REGS));
    end

    // Data-phase source: selected register lane, or all ones for an unknown register.
    always_comb begin
        sel_data_s = {DATA_W{1'b1}};
        for (int i = 0; i < N_REGS; i++) begin
            if (valid_s && (off_s == 8'(i))) begin
`ifdef SPI_READBACK_EN
                sel_data_s = wr_data_r[i*DATA_W +: DATA_W];
`else
                sel_data_s = rd_in[i*DATA_W +: DATA_W];
`endif
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Wrong-length frame to a real register; length 0 is a legal read-only frame.
    always_comb begin
        set_err_s = cs_rise_s && valid_s &&
                    (bitcnt_r != {CNT_W{1'b0}}) && (bitcnt_r != CNT_FULL);
    end

    // Shift engine and commit. CS edges take priority over a coincident SCK edge.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            regnum_r    <= 8'h00;
            bitcnt_r    <= '0;
            shift_in_r  <= '0;
            shift_out_r <= '0;
            wr_data_r   <= '0;
            commit_r    <= '0;
            wr_stb_r    <= '0;
        end else begin
            // Strobe trails the data update by one cycle.
            wr_stb_r <= commit_r;
            commit_r <= '0;
            if (cs_fall_s) begin
                shift_out_r <= sel_data_s;
                shift_in_r  <= '0;
                bitcnt_r    <= '0;
            end else if (cs_rise_s) begin
                shift_out_r <= DATA_W'(status_in);
                regnum_r    <= 8'h00;
                bitcnt_r    <= '0;
                if (valid_s && (bitcnt_r == CNT_FULL)) begin
                    for (int i = 0; i < N_REGS; i++) begin
                        if (off_s == 8'(i)) begin
                            wr_data_r[i*DATA_W +: DATA_W] <= shift_in_r;
                            commit_r[i]                   <= 1'b1;
                        end
                    end
                end
            end else if (sck_rise_s) begin
                shift_out_r <= {1'b0, shift_out_r[DATA_W-1:1]};
                if (state_r == PH_ADDR) begin
                    regnum_r <= {sdo_s, regnum_r[7:1]};
                end else begin
                    shift_in_r <= {sdo_s, shift_in_r[DATA_W-1:1]};
                    if (bitcnt_r != CNT_SAT) begin
                        bitcnt_r <= bitcnt_r + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Sticky frame error; a new error in the clearing cycle wins.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
        end else if (set_err_s) begin
            frame_err_r <= 1'b1;
        end else if (err_clr) begin
            frame_err_r <= 1'b0;
        end
    end

`ifdef SPI_READBACK_EN
    assign unused_s = &{1'b0, sck_lvl_s, sck_fall_s, ^rd_in};
`else
    assign unused_s = &{1'b0, sck_lvl_s, sck_fall_s};
`endif

    assign spidi     = shift_out_r[0];
    assign wr_data   = wr_data_r;
    assign wr_stb    = wr_stb_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_regslave.sv
// tb_spi_regslave
// Directed self-checking bench: an 8-bit/4-register instance (dut_a) and a
// 32-bit/16-register instance (dut_b) share SCK and MOSI, each has its own
// chip select. Expected values are hand-computed constants.

module tb_spi_regslave;

    localparam int HALF = 4;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         fclk;
    logic         rst_n;
    logic         spics_a, spics_b, spick, spido, err_clr;
    logic [7:0]   status_in;
    logic [31:0]  rd_in_a;
    logic [511:0] rd_in_b;
    logic         spidi_a, spidi_b, frame_err_a, frame_err_b;
    logic [31:0]  wr_data_a;
    logic [511:0] wr_data_b;
    logic [3:0]   wr_stb_a;
    logic [15:0]  wr_stb_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  miso_addr;
    logic [63:0] miso_data;
    logic [15:0] stb_or;
    int          stb_cnt, stb_first, data_first;

    spi_regslave #(.DATA_W(8), .N_REGS(4), .BASE_ADDR(8'h40), .SYNC_STAGES(2)) dut_a (
        .fclk(fclk), .rst_n(rst_n), .spics_n(spics_a), .spick(spick), .spido(spido),
        .spidi(spidi_a), .status_in(status_in), .rd_in(rd_in_a), .wr_data(wr_data_a),
        .wr_stb(wr_stb_a), .frame_err(frame_err_a), .err_clr(err_clr)
    );

    spi_regslave #(.DATA_W(32), .N_REGS(16), .BASE_ADDR(8'h40), .SYNC_STAGES(2)) dut_b (
        .fclk(fclk), .rst_n(rst_n), .spics_n(spics_b), .spick(spick), .spido(spido),
        .spidi(spidi_b), .status_in(status_in), .rd_in(rd_in_b), .wr_data(wr_data_b),
        .wr_stb(wr_stb_b), .frame_err(frame_err_b), .err_clr(err_clr)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge fclk);
    endtask

    task automatic cs_set(input logic sel, input logic v);
        if (sel) spics_b = v;
        else     spics_a = v;
    endtask

    // Address byte LSB first while CS is high; MISO sampled before each rise.
    task automatic addr_phase(input logic sel, input logic [7:0] addr);
        for (int i = 0; i < 8; i++) begin
            spido = addr[i];
            wait_cyc(HALF);
            miso_addr[i] = sel ? spidi_b : spidi_a;
            spick = 1'b1;
            wait_cyc(HALF);
            spick = 1'b0;
        end
        wait_cyc(HALF);
        cs_set(sel, 1'b0);
        wait_cyc(8);
    endtask

    task automatic data_bits(input logic sel, input logic [63:0] data, input int nbits);
        miso_data = '0;
        for (int i = 0; i < nbits; i++) begin
            spido = data[i];
            wait_cyc(HALF);
            miso_data[i] = sel ? spidi_b : spidi_a;
            spick = 1'b1;
            wait_cyc(HALF);
            spick = 1'b0;
        end
        spido = 1'b0;
    endtask

    // Close the frame and watch the commit window cycle by cycle.
    task automatic end_frame(input logic sel);
        logic [31:0]  pa;
        logic [511:0] pb;
        logic [15:0]  sv;
        wait_cyc(HALF);
        pa = wr_data_a;
        pb = wr_data_b;
        cs_set(sel, 1'b1);
        stb_or = '0; stb_cnt = 0; stb_first = -1; data_first = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge fclk);
            sv = sel ? wr_stb_b : {12'h000, wr_stb_a};
            if (sv != 16'h0000) begin
                stb_or = stb_or | sv;
                stb_cnt++;
                if (stb_first < 0) stb_first = k;
            end
            if (data_first < 0 && (sel ? (wr_data_b !== pb) : (wr_data_a !== pa)))
                data_first = k;
        end
    endtask

    task automatic frame(input logic sel, input logic [7:0] addr,
                         input logic [63:0] data, input int nbits);
        addr_phase(sel, addr);
        data_bits(sel, data, nbits);
        end_frame(sel);
    endtask

    initial begin
        rst_n = 1'b0; spics_a = 1'b1; spics_b = 1'b1; spick = 1'b0; spido = 1'b0;
        err_clr = 1'b0; status_in = 8'h5C;
        rd_in_a = {8'h11, 8'h22, 8'h3C, 8'h96};
        rd_in_b = '0;
        wait_cyc(4);
        check("rst_spidi", spidi_a, 1'b0);
        check("rst_wr_data", wr_data_a, 32'h0);
        check("rst_wr_stb", wr_stb_a, 4'h0);
        check("rst_frame_err", frame_err_a, 1'b0);
        rst_n = 1'b1;
        wait_cyc(4);

        // Full write of A5 to register 1.
        frame(1'b0, 8'h41, 64'hA5, 8);
        check("t1_miso_addr_reset", miso_addr, 8'h00);
        check("t1_miso_data", miso_data, RB ? 64'h00 : 64'h3C);
        check("t1_wr_data", wr_data_a, 32'h0000A500);
        check("t1_stb_value", stb_or, 16'h0002);
        check("t1_stb_count", stb_cnt, 1);
        check("t1_stb_after_data", stb_first, data_first + 1);
        check("t1_no_err", frame_err_a, 1'b0);

        // Short frame to a valid register.
        frame(1'b0, 8'h41, 64'h1F, 5);
        check("t2_miso_status", miso_addr, 8'h5C);
        check("t2_wr_data_kept", wr_data_a, 32'h0000A500);
        check("t2_no_stb", stb_cnt, 0);
        check("t2_err_set", frame_err_a, 1'b1);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        wait_cyc(1);
        check("t2_err_cleared", frame_err_a, 1'b0);

        // Registers just below and just above the window.
        frame(1'b0, 8'h3F, 64'h12, 8);
        check("t3_lo_miso_ff", miso_data, 64'hFF);
        check("t3_lo_no_stb", stb_cnt, 0);
        check("t3_lo_no_err", frame_err_a, 1'b0);
        frame(1'b0, 8'h44, 64'h34, 8);
        check("t3_hi_miso_ff", miso_data, 64'hFF);
        check("t3_hi_no_stb", stb_cnt, 0);
        check("t3_hi_no_err", frame_err_a, 1'b0);
        check("t3_wr_data_kept", wr_data_a, 32'h0000A500);

        // Read path of register 0, with a write of 77.
        frame(1'b0, 8'h40, 64'h77, 8);
        check("t4_miso_status", miso_addr, 8'h5C);
        check("t4_miso_data", miso_data, RB ? 64'h00 : 64'h96);
        check("t4_wr_data", wr_data_a, 32'h0000A577);
        check("t4_stb_value", stb_or, 16'h0001);

        // Read-only (zero-length) frame.
        frame(1'b0, 8'h40, 64'h0, 0);
        check("t5_no_stb", stb_cnt, 0);
        check("t5_no_err", frame_err_a, 1'b0);

        // Over-long frame (9 bits) to register 2.
        frame(1'b0, 8'h42, 64'h1AA, 9);
        check("t6_no_stb", stb_cnt, 0);
        check("t6_err_set", frame_err_a, 1'b1);
        check("t6_wr_data_kept", wr_data_a, 32'h0000A577);

        // Reset in the middle of a data phase.
        addr_phase(1'b0, 8'h40);
        data_bits(1'b0, 64'h0F, 4);
        rst_n = 1'b0;
        spick = 1'b0;
        spics_a = 1'b1;
        wait_cyc(3);
        check("t7_rst_wr_data", wr_data_a, 32'h0);
        check("t7_rst_stb", wr_stb_a, 4'h0);
        check("t7_rst_err", frame_err_a, 1'b0);
        check("t7_rst_spidi", spidi_a, 1'b0);
        rst_n = 1'b1;
        stb_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge fclk);
            if (wr_stb_a != 4'h0) stb_cnt++;
        end
        check("t7_no_stb_after_release", stb_cnt, 0);
        frame(1'b0, 8'h40, 64'hC3, 8);
        check("t7_recommit_data", wr_data_a, 32'h000000C3);
        check("t7_recommit_stb", stb_or, 16'h0001);
        check("t7_recommit_count", stb_cnt, 1);

        // Wide instance, top register.
        frame(1'b1, 8'h4F, 64'hDEADBEEF, 32);
        check("t8_wr_data_top", wr_data_b[511:480], 32'hDEADBEEF);
        check("t8_wr_data_rest", wr_data_b[479:0] == '0, 1'b1);
        check("t8_stb_value", stb_or, 16'h8000);
        check("t8_stb_count", stb_cnt, 1);
        check("t8_no_err", frame_err_b, 1'b0);
        check("t8_other_dut_kept", wr_data_a, 32'h000000C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
